// File: rtl/aes_hw_verify_ctrl_if.sv
// ROM fetch and AES core handshake bundle for the verification sequencer.
// master = sequencer side, slave = ROM/AES side.
interface aes_hw_verify_ctrl_if #(
    parameter int DATA_W = 128,
    parameter int KEY_W  = 128,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0]         rom_addr;
    logic [KEY_W+2*DATA_W-1:0] rom_data;
    logic                      dut_in_valid;
    logic                      dut_in_ready;
    logic [KEY_W-1:0]          dut_key;
    logic [DATA_W-1:0]         dut_din;
    logic                      dut_out_valid;
    logic [DATA_W-1:0]         dut_dout;

    modport master (
        output rom_addr,
        output dut_in_valid,
        output dut_key,
        output dut_din,
        input  rom_data,
        input  dut_in_ready,
        input  dut_out_valid,
        input  dut_dout
    );

    modport slave (
        input  rom_addr,
        input  dut_in_valid,
        input  dut_key,
        input  dut_din,
        output rom_data,
        output dut_in_ready,
        output dut_out_valid,
        output dut_dout
    );
endinterface

// File: rtl/aes_hw_verify_ctrl.sv
// Golden-vector sequencer: fetches {key, pt, ct} from ROM, drives the AES core,
// checks results and keeps saturating total/correct/timeout counts.
module aes_hw_verify_ctrl #(
    parameter int DATA_W  = 128,
    parameter int KEY_W   = 128,
    parameter int NUM_VEC = 256,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     work,
    input  logic                     continuous,
    input  logic                     stop_on_err,
    aes_hw_verify_ctrl_if.master     bus,
    output logic [CNT_W-1:0]         total,
    output logic [CNT_W-1:0]         correct,
    output logic [CNT_W-1:0]         timeouts,
    output logic                     fail_seen,
    output logic [ADDR_W-1:0]        first_fail_idx,
    output logic                     busy,
    output logic                     done
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_work_q;
    logic                r_cont;
    logic                r_soe;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic                r_in_valid;
    logic [KEY_W-1:0]    r_key;
    logic [DATA_W-1:0]   r_din;
    logic [DATA_W-1:0]   r_exp;
    logic [DATA_W-1:0]   r_res;
    logic                r_to;
    logic [TW-1:0]       r_timer;
    logic [CNT_W-1:0]    r_total;
    logic [CNT_W-1:0]    r_correct;
    logic [CNT_W-1:0]    r_timeouts;
    logic                r_fail_seen;
    logic [ADDR_W-1:0]   r_ffi;
    logic                r_busy;
    logic                r_done;

    logic                w_rise;
    logic                w_fail;
    logic                w_last;
    logic                w_tmo;
    logic [ADDR_W-1:0]   w_nidx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_rise = work & ~r_work_q;
    // A timeout fails the vector even if the stale result register matches.
    assign w_fail = r_to | (r_res != r_exp);
    assign w_last = (r_idx == ADDR_W'(NUM_VEC - 1));
    assign w_tmo  = (r_timer == TW'(TIMEOUT - 1));
    assign w_nidx = w_last ? '0 : r_idx + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_work_q    <= 1'b0;
            r_cont      <= 1'b0;
            r_soe       <= 1'b0;
            r_idx       <= '0;
            r_rom_addr  <= '0;
            r_in_valid  <= 1'b0;
            r_key       <= '0;
            r_din       <= '0;
            r_exp       <= '0;
            r_res       <= '0;
            r_to        <= 1'b0;
            r_timer     <= '0;
            r_total     <= '0;
            r_correct   <= '0;
            r_timeouts  <= '0;
            r_fail_seen <= 1'b0;
            r_ffi       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_work_q <= work;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_rise) begin
                        r_cont      <= continuous;
                        r_soe       <= stop_on_err;
                        r_idx       <= '0;
                        r_rom_addr  <= '0;
                        r_total     <= '0;
                        r_correct   <= '0;
                        r_timeouts  <= '0;
                        r_fail_seen <= 1'b0;
                        r_ffi       <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_state     <= S_FETCH;
                    end else if (!work && r_state == S_DONE) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    r_rom_addr <= r_idx;
                    r_state    <= S_LOAD;
                end
                S_LOAD: begin
                    r_key      <= bus.rom_data[KEY_W+2*DATA_W-1 -: KEY_W];
                    r_din      <= bus.rom_data[2*DATA_W-1 -: DATA_W];
                    r_exp      <= bus.rom_data[DATA_W-1:0];
                    r_in_valid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (bus.dut_in_ready) begin
                        r_in_valid <= 1'b0;
                        r_timer    <= '0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A result in the expiry cycle still wins over the timeout.
                    if (bus.dut_out_valid) begin
                        r_res   <= bus.dut_dout;
                        r_to    <= 1'b0;
                        r_state <= S_CHECK;
                    end else if (w_tmo) begin
                        r_to    <= 1'b1;
                        r_state <= S_CHECK;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_CHECK: begin
                    r_total <= sat_inc(r_total);
                    if (!w_fail) r_correct <= sat_inc(r_correct);
                    if (r_to) r_timeouts <= sat_inc(r_timeouts);
                    if (w_fail && !r_fail_seen) begin
                        r_fail_seen <= 1'b1;
                        r_ffi       <= r_idx;
                    end
                    if (r_soe && w_fail) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (!work) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_last && !r_cont) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx      <= w_nidx;
                        r_rom_addr <= w_nidx;
                        r_state    <= S_FETCH;
                    end
                end
                default: begin
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_in_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr     = r_rom_addr;
    assign bus.dut_in_valid = r_in_valid;
    assign bus.dut_key      = r_key;
    assign bus.dut_din      = r_din;
    assign total            = r_total;
    assign correct          = r_correct;
    assign timeouts         = r_timeouts;
    assign fail_seen        = r_fail_seen;
    assign first_fail_idx   = r_ffi;
    assign busy             = r_busy;
    assign done             = r_done;
endmodule

// File: tb/tb_aes_hw_verify_ctrl.sv
// Scoreboard bench for aes_hw_verify_ctrl: ROM + AES behavioural models,
// expected handshakes and end-of-pass status queued and checked by a monitor.
module tb_aes_hw_verify_ctrl;
    localparam int DATA_W  = 128;
    localparam int KEY_W   = 128;
    localparam int NUM_VEC = 4;
    localparam int ADDR_W  = 2;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic work = 1'b0;
    logic continuous = 1'b0;
    logic stop_on_err = 1'b0;
    logic [CNT_W-1:0]  total, correct, timeouts;
    logic              fail_seen;
    logic [ADDR_W-1:0] first_fail_idx;
    logic              busy, done;

    always #5 clk = ~clk;

    aes_hw_verify_ctrl_if #(.DATA_W(DATA_W), .KEY_W(KEY_W), .ADDR_W(ADDR_W)) bus ();

    aes_hw_verify_ctrl #(
        .DATA_W(DATA_W), .KEY_W(KEY_W), .NUM_VEC(NUM_VEC),
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .work(work),
        .continuous(continuous), .stop_on_err(stop_on_err),
        .bus(bus),
        .total(total), .correct(correct), .timeouts(timeouts),
        .fail_seen(fail_seen), .first_fail_idx(first_fail_idx),
        .busy(busy), .done(done)
    );

    typedef struct { int idx; int gap; } hs_t;
    typedef struct { int tot; int cor; int tmo; int fail; int ffi; } st_t;
    hs_t q_hs[$];
    st_t q_st[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int hs_count = 0;
    int last_hs = 0;
    int corrupt_idx = -1;
    int silent_idx = -1;

    function automatic logic [127:0] key_of(input int i);
        logic [31:0] w;
        w = 32'hA500_0000 | 32'(i);
        return {w, w ^ 32'h1111_1111, w, w ^ 32'h2222_2222};
    endfunction
    function automatic logic [127:0] pt_of(input int i);
        logic [31:0] w;
        w = 32'h5000_0000 | 32'(i * 3);
        return {w, w, w ^ 32'h0F0F_0F0F, w};
    endfunction
    function automatic logic [127:0] ct_of(input int i);
        logic [31:0] w;
        w = 32'hC000_0000 | 32'(i * 17);
        return {w ^ 32'hDEAD_BEEF, w, w, w};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous ROM, one cycle of latency
    always @(posedge clk)
        bus.rom_data <= {key_of(int'(bus.rom_addr)), pt_of(int'(bus.rom_addr)),
                         ct_of(int'(bus.rom_addr))};

    // AES model: answers the cycle after handshake unless silenced/corrupted
    always @(posedge clk) begin
        bus.dut_out_valid <= 1'b0;
        if (bus.dut_in_valid && bus.dut_in_ready &&
            int'(bus.rom_addr) != silent_idx) begin
            bus.dut_out_valid <= 1'b1;
            bus.dut_dout <= ct_of(int'(bus.rom_addr)) ^
                (int'(bus.rom_addr) == corrupt_idx ? 128'h1 : 128'h0);
        end
    end

    // monitor
    initial begin
        hs_t e;
        st_t s;
        logic done_q;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.dut_in_valid === 1'b1 && bus.dut_in_ready === 1'b1) begin
                if (q_hs.size() == 0) begin
                    chk("unexpected_handshake", 1, 0);
                end else begin
                    e = q_hs.pop_front();
                    chk("hs_rom_addr", bus.rom_addr, e.idx);
                    chk("hs_key", bus.dut_key, key_of(e.idx));
                    chk("hs_din", bus.dut_din, pt_of(e.idx));
                    if (e.gap > 0) chk("hs_gap", cyc - last_hs, e.gap);
                end
                last_hs = cyc;
                hs_count++;
            end
            if (done === 1'b1 && done_q !== 1'b1) begin
                if (q_st.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    s = q_st.pop_front();
                    chk("st_total", total, s.tot);
                    chk("st_correct", correct, s.cor);
                    chk("st_timeouts", timeouts, s.tmo);
                    chk("st_fail_seen", fail_seen, s.fail);
                    chk("st_first_fail_idx", first_fail_idx, s.ffi);
                    chk("st_busy_with_done", busy, 0);
                end
            end
            done_q = done;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit cond(input int which, input int tgt);
        case (which)
            0:       return done === 1'b1;
            1:       return busy === 1'b0 && done === 1'b0;
            2:       return bus.dut_in_valid === 1'b1;
            default: return hs_count >= tgt;
        endcase
    endfunction

    task automatic wait_for(input int which, input int tgt, input int max, input string nm);
        int k;
        k = 0;
        while (!cond(which, tgt) && k < max) begin
            @(negedge clk);
            k++;
        end
        if (!cond(which, tgt)) chk(nm, 0, 1);
    endtask

    task automatic start_pass(input bit cont, input bit soe);
        @(negedge clk);
        continuous  = cont;
        stop_on_err = soe;
        work        = 1'b1;
    endtask

    task automatic stop_pass();
        work = 1'b0;
        wait_for(1, 0, 40, "wait_idle_bound");
    endtask

    task automatic push_hs(input int idx, input int gap);
        hs_t e;
        e.idx = idx;
        e.gap = gap;
        q_hs.push_back(e);
    endtask

    task automatic push_st(input int t, input int c, input int to, input int f, input int ff);
        st_t s;
        s.tot = t; s.cor = c; s.tmo = to; s.fail = f; s.ffi = ff;
        q_st.push_back(s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int base;
        bus.dut_in_ready = 1'b1;
        tick(3);
        chk("rst_total", total, 0);
        chk("rst_correct", correct, 0);
        chk("rst_timeouts", timeouts, 0);
        chk("rst_fail_seen", fail_seen, 0);
        chk("rst_ffi", first_fail_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_valid", bus.dut_in_valid, 0);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_key", bus.dut_key, 0);
        chk("rst_din", bus.dut_din, 0);
        rst_n = 1'b1;
        tick(2);

        // all vectors good, 20 cycles per pass
        push_hs(0, 0); push_hs(1, 5); push_hs(2, 5); push_hs(3, 5);
        push_st(4, 4, 0, 0, 0);
        start_pass(0, 0);
        @(posedge clk);
        #1 t0 = cyc;
        wait_for(0, 0, 100, "t1_done_bound");
        chk("t1_latency", cyc - t0, 20);
        chk("t1_busy_clear", busy, 0);
        stop_pass();
        chk("t1_done_dropped", done, 0);

        // vector 2 corrupted
        corrupt_idx = 2;
        push_hs(0, 0); push_hs(1, 5); push_hs(2, 5); push_hs(3, 5);
        push_st(4, 3, 0, 1, 2);
        start_pass(0, 0);
        wait_for(0, 0, 100, "t2_done_bound");
        stop_pass();

        // same, halting at first failure
        push_hs(0, 0); push_hs(1, 5); push_hs(2, 5);
        push_st(3, 2, 0, 1, 2);
        start_pass(0, 1);
        wait_for(0, 0, 100, "t3_done_bound");
        stop_pass();
        corrupt_idx = -1;

        // vector 1 never answered: WAIT of 8 pushes next handshake to 12
        silent_idx = 1;
        push_hs(0, 0); push_hs(1, 5); push_hs(2, 12); push_hs(3, 5);
        push_st(4, 3, 1, 1, 1);
        start_pass(0, 0);
        wait_for(0, 0, 200, "t4_done_bound");
        stop_pass();
        silent_idx = -1;

        // continuous: 18 vectors, counters saturate at 15, never done
        for (int i = 0; i < 18; i++) push_hs(i % 4, (i == 0) ? 0 : 5);
        base = hs_count;
        start_pass(1, 0);
        wait_for(3, base + 18, 200, "t5_hs_bound");
        work = 1'b0;
        wait_for(1, 0, 40, "t5_idle_bound");
        chk("t5_total_sat", total, 15);
        chk("t5_correct_sat", correct, 15);
        chk("t5_timeouts", timeouts, 0);
        chk("t5_done", done, 0);

        // work dropped during a stalled SEND
        bus.dut_in_ready = 1'b0;
        push_hs(0, 0);
        start_pass(0, 0);
        wait_for(2, 0, 20, "t6_valid_bound");
        work = 1'b0;
        tick(3);
        chk("t6_valid_held", bus.dut_in_valid, 1);
        chk("t6_key_held", bus.dut_key, key_of(0));
        @(posedge clk);
        #1 bus.dut_in_ready = 1'b1;
        wait_for(1, 0, 40, "t6_idle_bound");
        chk("t6_total", total, 1);
        chk("t6_correct", correct, 1);
        chk("t6_done", done, 0);

        // async reset while waiting for a result
        silent_idx = 0;
        push_hs(0, 0);
        base = hs_count;
        start_pass(0, 0);
        wait_for(3, base + 1, 30, "t7_hs_bound");
        tick(3);
        chk("t7_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        work = 1'b0;
        #1;
        chk("t7_valid", bus.dut_in_valid, 0);
        chk("t7_busy", busy, 0);
        chk("t7_key", bus.dut_key, 0);
        chk("t7_din", bus.dut_din, 0);
        tick(1);
        chk("t7_total", total, 0);
        chk("t7_done", done, 0);
        rst_n = 1'b1;
        silent_idx = -1;
        tick(5);

        chk("hs_queue_empty", q_hs.size(), 0);
        chk("st_queue_empty", q_st.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/aes_hw_verify_ctrl.md
# aes_hw_verify_ctrl

Parametrised self-checking sequencer for on-chip AES verification. It fetches golden vectors (key, plaintext, expected ciphertext) from an external synchronous ROM and drives them into the AES core over a valid/ready handshake. Each result is compared against the expected value and total/correct/timeout counts are accumulated. Added behaviour: configurable vector count, single-pass or continuous mode, stop-on-error, response timeout, and first-failure capture.

## Interface
Parameters:
- DATA_W, 128, plaintext/ciphertext width
- KEY_W, 128, key width
- NUM_VEC, 256, vectors per pass (1..2^ADDR_W)
- ADDR_W, 8, ROM address width
- CNT_W, 16, counter width
- TIMEOUT, 1023, max cycles waiting for a DUT result (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- work  in  1  level; rising edge starts a fresh pass, low requests stop
- continuous  in  1  1 = wrap to vector 0 after NUM_VEC-1; sampled at pass start
- stop_on_err  in  1  1 = halt at first mismatch/timeout; sampled at pass start
- rom_addr  out  ADDR_W  vector index
- rom_data  in  KEY_W+2*DATA_W  {key, plaintext, expected}; valid 1 cycle after rom_addr
- dut_in_valid  out  1  key/plaintext valid
- dut_in_ready  in  1  DUT accepts
- dut_key  out  KEY_W
- dut_din  out  DATA_W
- dut_out_valid  in  1  one-cycle pulse, result valid
- dut_dout  in  DATA_W  DUT ciphertext
- total  out  CNT_W  vectors checked
- correct  out  CNT_W  vectors matching
- timeouts  out  CNT_W  vectors with no result
- fail_seen  out  1  sticky, any mismatch/timeout this pass
- first_fail_idx  out  ADDR_W  index of first failure
- busy  out  1  FSM not in IDLE/DONE
- done  out  1  pass finished (single-pass or halted)

## Operation
- States: IDLE, FETCH, LOAD, SEND, WAIT, CHECK, DONE.
- Reset: state IDLE; all outputs 0. This covers rom_addr, dut_key, dut_din, the counters, first_fail_idx, fail_seen, busy, done and dut_in_valid.
- work is registered once for edge detection. A rising edge, in IDLE or DONE, clears the counters, index, fail_seen and first_fail_idx, latches the mode bits, and moves to FETCH.
- FETCH: drive rom_addr = index, go to LOAD.
- LOAD: register key and plaintext onto dut_key and dut_din; register expected internally; go to SEND.
- SEND: dut_in_valid = 1, with data held stable until dut_in_ready. On handshake, drop valid, clear the timer, go to WAIT.
- WAIT: on dut_out_valid, capture dut_dout and go to CHECK. If the timer reaches TIMEOUT, flag a timeout and go to CHECK. dut_out_valid outside WAIT is ignored.
- CHECK:
  - total += 1.
  - On match, correct += 1.
  - On timeout, timeouts += 1; this counts as a failure even if the data would match.
  - On first failure of the pass: fail_seen = 1, first_fail_idx = index.
- After CHECK, the next state is decided in priority order:
  - stop_on_err and failure → DONE.
  - work low → IDLE (counters hold, done = 0).
  - index = NUM_VEC-1 and not continuous → DONE.
  - Otherwise index advances (wrapping to 0 after NUM_VEC-1) → FETCH.
- work low in any other state is honoured only at CHECK. A started vector always completes, bounded by TIMEOUT.
- DONE: done = 1 and held. work low → IDLE with done cleared. A new rising edge restarts the pass.
- Counters saturate at 2^CNT_W-1 and never wrap. Continuous mode runs indefinitely.
- Comparison is full DATA_W equality.

## Timing
- Per vector, minimum 5 cycles: FETCH, LOAD, SEND (DUT ready immediately), WAIT (result the next cycle), CHECK.
- rom_addr is registered in FETCH; rom_data is sampled on the LOAD edge.
- Counter updates are visible the cycle after CHECK.
- Timeout: with no result, WAIT lasts exactly TIMEOUT cycles.
- dut_in_valid is never deasserted before handshake. A result arriving in the same cycle as the timer expiry counts as a valid result, not a timeout.
- busy = 1 in FETCH..CHECK. done and busy are never both 1.
- Asynchronous reset mid-transaction returns to IDLE immediately, with dut_in_valid = 0.

## Test plan
- NUM_VEC=4, DUT model always correct, ready immediate, latency 1; work rises → done after 20 cycles; total=4, correct=4, fail_seen=0.
- Vector 2 corrupted, stop_on_err=0 → total=4, correct=3, first_fail_idx=2, fail_seen=1, done=1.
- Same with stop_on_err=1 → done after vector 2; total=3, correct=2, first_fail_idx=2.
- TIMEOUT=8, DUT never answers vector 1 → WAIT lasts exactly 8 cycles; timeouts=1, correct=3, total=4.
- continuous=1, NUM_VEC=4, CNT_W=4 → rom_addr sequence 0,1,2,3,0…; total saturates at 15; done stays 0.
- work dropped during SEND with ready held low for 3 cycles → handshake, result and CHECK still occur; then IDLE, total=1. rst_n pulsed in WAIT → all outputs 0 next cycle.
